// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable oversample / bit tick generator for the UART
// RX/TX paths of the debug/load link.
//
// A period counter produces a one-clock sample_tick every `period` enabled
// clocks. A power-of-two oversample counter derives mid_tick (bit centre)
// and bit_tick (bit end) from the sample ticks. New divisors are staged in
// a shadow register and swapped in only at a period boundary, so a running
// period is never shortened or stretched by a reload.
//
// Optional feature macro: BAUD_FRAC_EN
//   defined   - fractional accumulator adds 1/2^FRAC_WIDTH resolution to
//               the divisor (average period = div + frac/2^FRAC_WIDTH).
//   undefined - cfg_frac is accepted but ignored; period is exactly div.

module baud_tick_gen #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 19200,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int FRAC_WIDTH  = 4,
  parameter int DEFAULT_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  resync,
  input  logic                  cfg_load,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  output logic                  cfg_err,
  output logic [DIV_WIDTH-1:0]  div_active,
  output logic                  sample_tick,
  output logic                  mid_tick,
  output logic                  bit_tick
);

  localparam int                   OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]      OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   CNT_ONE = (DIV_WIDTH + 1)'(1);

  // State
  logic [DIV_WIDTH:0]   r_cnt;        // one bit wider so div+carry never overflows
  logic [OS_W-1:0]      r_os_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_div_shadow;
  logic                 r_pending;
  logic                 r_cfg_err;
  logic                 r_sample_tick;
  logic                 r_mid_tick;
  logic                 r_bit_tick;

  // Combinational
  logic                 w_carry;
  logic [DIV_WIDTH:0]   w_period;
  logic                 w_tc;
  logic                 w_hold;
  logic                 w_load_ok;
  logic                 w_apply_in;
  logic                 w_apply_sh;
  logic                 w_apply;

  // Divisors 0 and 1 cannot produce a meaningful tick stream; reject them.
  assign w_load_ok  = cfg_load && (cfg_div > DIV_ONE);

  // While stopped or realigning there is no running period to protect, so a
  // new divisor may take effect right away.
  assign w_hold     = resync || !enable;

  // A valid load in a hold cycle bypasses the shadow. Otherwise a pending
  // shadow value is swapped in at the period boundary (or on hold). A valid
  // load on a boundary cycle wins and re-arms the shadow for the next one.
  assign w_apply_in = w_load_ok && w_hold;
  assign w_apply_sh = !w_load_ok && r_pending && (w_hold || w_tc);
  assign w_apply    = w_apply_in || w_apply_sh;

  assign w_period   = {1'b0, r_div} + {{DIV_WIDTH{1'b0}}, w_carry};

  // >= rather than == so that a divisor shrunk while disabled (counter
  // already past the new end) still terminates instead of running to wrap.
  assign w_tc       = enable && !resync && (r_cnt >= (w_period - CNT_ONE));

`ifdef BAUD_FRAC_EN
  logic [FRAC_WIDTH-1:0] r_frac;
  logic [FRAC_WIDTH-1:0] r_frac_shadow;
  logic [FRAC_WIDTH-1:0] r_acc;
  logic [FRAC_WIDTH:0]   w_acc_sum;

  // The carry out of acc+frac stretches the period that is currently
  // running, so the first overflow lands on the last of 2^W/frac periods.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac};
  assign w_carry   = w_acc_sum[FRAC_WIDTH];

  // Fractional accumulator: restarts on realign or divisor change.
  always_ff @(posedge clock) begin
    if (reset || resync)  r_acc <= '0;
    else if (w_apply)     r_acc <= '0;
    else if (w_tc)        r_acc <= w_acc_sum[FRAC_WIDTH-1:0];
  end

  // Active and shadow fractional divisor, tracking the integer divisor.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frac        <= '0;
      r_frac_shadow <= '0;
    end else if (w_apply_in) begin
      r_frac        <= cfg_frac;
    end else if (w_load_ok) begin
      r_frac_shadow <= cfg_frac;
    end else if (w_apply_sh) begin
      r_frac        <= r_frac_shadow;
    end
  end
`else
  logic w_unused_frac;

  assign w_carry       = 1'b0;
  assign w_unused_frac = ^cfg_frac;
`endif

  // Period counter: counts enabled clocks, wraps at terminal count.
  always_ff @(posedge clock) begin
    if (reset || resync) r_cnt <= '0;
    else if (w_tc)       r_cnt <= '0;
    else if (enable)     r_cnt <= r_cnt + CNT_ONE;
  end

  // Oversample phase: advances once per sample tick, wraps naturally.
  always_ff @(posedge clock) begin
    if (reset || resync) r_os_cnt <= '0;
    else if (w_tc)       r_os_cnt <= r_os_cnt + OS_W'(1);
  end

  // Registered ticks, all issued the cycle after a terminal count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sample_tick <= 1'b0;
      r_mid_tick    <= 1'b0;
      r_bit_tick    <= 1'b0;
    end else begin
      r_sample_tick <= w_tc;
      r_mid_tick    <= w_tc && (r_os_cnt == OS_MID);
      r_bit_tick    <= w_tc && (r_os_cnt == OS_LAST);
    end
  end

  // Integer divisor: active value, shadow and pending flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div        <= DIV_RST;
      r_div_shadow <= '0;
      r_pending    <= 1'b0;
    end else if (w_apply_in) begin
      r_div        <= cfg_div;
      r_pending    <= 1'b0;
    end else if (w_load_ok) begin
      r_div_shadow <= cfg_div;
      r_pending    <= 1'b1;
    end else if (w_apply_sh) begin
      r_div        <= r_div_shadow;
      r_pending    <= 1'b0;
    end
  end

  // Rejected-load flag, one cycle after the offending cfg_load.
  always_ff @(posedge clock) begin
    if (reset) r_cfg_err <= 1'b0;
    else       r_cfg_err <= cfg_load && !w_load_ok;
  end

  assign cfg_err     = r_cfg_err;
  assign div_active  = r_div;
  assign sample_tick = r_sample_tick;
  assign mid_tick    = r_mid_tick;
  assign bit_tick    = r_bit_tick;

endmodule
